// File: rtl/lc3_wb_pkg.sv
// lc3_wb_pkg: shared types, sizes and condition-code helpers for the LC3 writeback stage.
package lc3_wb_pkg;
    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 16;
    localparam int AW       = $clog2(NUM_REGS);
    typedef enum logic [1:0] {
        WB_ALU     = 2'b00,
        WB_MEM     = 2'b01,
        WB_PC      = 2'b10,
        WB_ILLEGAL = 2'b11
    } wb_sel_t;
    localparam logic [2:0] PSR_N = 3'b100;
    localparam logic [2:0] PSR_Z = 3'b010;
    localparam logic [2:0] PSR_P = 3'b001;
    typedef logic [AW-1:0] reg_addr_t;
    function automatic logic [2:0] psr_of(input logic [DATA_W-1:0] d);
        return d[DATA_W-1] ? PSR_N : (d == '0) ? PSR_Z : PSR_P;
    endfunction
endpackage

// File: rtl/lc3_writeback_if.sv
// lc3_writeback_if: execute_out bundle into writeback plus the register read-back path.
interface lc3_writeback_if;
    import lc3_wb_pkg::*;
    logic                enable_writeback;
    logic [1:0]          W_Control_in;
    reg_addr_t           dr;
    logic [DATA_W-1:0]   aluout;
    logic [DATA_W-1:0]   pcout;
    logic [DATA_W-1:0]   memout;
    reg_addr_t           sr1;
    reg_addr_t           sr2;
    logic [DATA_W-1:0]   VSR1;
    logic [DATA_W-1:0]   VSR2;
    logic [2:0]          psr;
    logic                wb_error;
    modport master (
        output enable_writeback, W_Control_in, dr, aluout, pcout, memout, sr1, sr2,
        input  VSR1, VSR2, psr, wb_error
    );
    modport slave (
        input  enable_writeback, W_Control_in, dr, aluout, pcout, memout, sr1, sr2,
        output VSR1, VSR2, psr, wb_error
    );
endinterface

// File: rtl/lc3_regfile.sv
// lc3_regfile: 8x16 architectural registers, one synchronous write port, two async read ports.
module lc3_regfile
    import lc3_wb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_we,
    input  reg_addr_t         i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  reg_addr_t         i_raddr1,
    input  reg_addr_t         i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);
    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_mem <= '{default: '0};
        else if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // No bypass: a read of the register being written returns its old value.
    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];
endmodule

// File: rtl/lc3_writeback.sv
// lc3_writeback: selects the execute/memory result, commits it to the register file,
// and maintains the NZP condition codes and a sticky illegal-select flag.
module lc3_writeback
    import lc3_wb_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    lc3_writeback_if.slave  wb
);
    wb_sel_t           w_sel;
    logic [DATA_W-1:0] w_data;
    logic              w_commit;
    logic              w_illegal;
    logic [2:0]        r_psr;
    logic              r_err;

    assign w_sel  = wb_sel_t'(wb.W_Control_in);
    assign w_data = (w_sel == WB_ALU) ? wb.aluout :
                    (w_sel == WB_MEM) ? wb.memout : wb.pcout;
    // Enable is tested first so an undriven select is ignored while idle.
    assign w_commit  = wb.enable_writeback && (w_sel != WB_ILLEGAL);
    assign w_illegal = wb.enable_writeback && (w_sel == WB_ILLEGAL);

    lc3_regfile u_regfile (
        .clock    (clock),
        .reset    (reset),
        .i_we     (w_commit),
        .i_waddr  (wb.dr),
        .i_wdata  (w_data),
        .i_raddr1 (wb.sr1),
        .i_raddr2 (wb.sr2),
        .o_rdata1 (wb.VSR1),
        .o_rdata2 (wb.VSR2)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_psr <= 3'b000;
            r_err <= 1'b0;
        end else begin
            if (w_commit) r_psr <= psr_of(w_data);
            if (w_illegal) r_err <= 1'b1;
        end
    end

    assign wb.psr      = r_psr;
    assign wb.wb_error = r_err;
endmodule

// File: tb/tb_lc3_writeback.sv
// tb_lc3_writeback: directed plus random stimulus against an array-based reference model,
// with expectations queued by the driver and compared by a separate negedge monitor.
module tb_lc3_writeback;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [15:0] v1;
        logic [15:0] v2;
        logic [2:0]  psr;
        logic        err;
        string       tag;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_r [8];
    logic [2:0]  m_psr;
    logic        m_err;

    lc3_writeback_if bus ();
    lc3_writeback dut (.clock(clock), .reset(reset), .wb(bus));

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, ".VSR1"}, bus.VSR1, e.v1);
            chk({e.tag, ".VSR2"}, bus.VSR2, e.v2);
            chk({e.tag, ".psr"}, {13'd0, bus.psr}, {13'd0, e.psr});
            chk({e.tag, ".wb_error"}, {15'd0, bus.wb_error}, {15'd0, e.err});
        end
    end

    // Drives one cycle (called at posedge+1), queues the expected read-back, then advances the model.
    task automatic step(input string tag, input logic en, input logic [1:0] sel, input logic [2:0] dr,
                        input logic [15:0] alu, input logic [15:0] pc, input logic [15:0] mem,
                        input logic [2:0] s1, input logic [2:0] s2);
        logic [15:0] d;
        bus.enable_writeback = en;
        bus.W_Control_in     = sel;
        bus.dr               = dr;
        bus.aluout           = alu;
        bus.pcout            = pc;
        bus.memout           = mem;
        bus.sr1              = s1;
        bus.sr2              = s2;
        q.push_back('{m_r[s1], m_r[s2], m_psr, m_err, tag});
        @(posedge clock);
        #1;
        if (reset && en) begin
            if (sel == 2'b11) m_err = 1'b1;
            else begin
                d = (sel == 2'b00) ? alu : (sel == 2'b01) ? mem : pc;
                m_r[dr] = d;
                m_psr = d[15] ? 3'b100 : (d == 16'h0) ? 3'b010 : 3'b001;
            end
        end
    endtask

    task automatic model_clear();
        foreach (m_r[i]) m_r[i] = 16'h0;
        m_psr = 3'b000;
        m_err = 1'b0;
    endtask

    function automatic logic [15:0] rnd16();
        int k;
        k = $urandom_range(0, 7);
        return (k == 0) ? 16'h0000 : (k == 1) ? 16'h8000 : 16'($urandom);
    endfunction

    task automatic rand_steps(input string tag, input int n);
        logic [1:0] sel;
        for (int i = 0; i < n; i++) begin
            sel = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            step(tag, $urandom_range(0, 3) != 0, sel, 3'($urandom), rnd16(), rnd16(), rnd16(),
                 3'($urandom), 3'($urandom));
        end
    endtask

    initial begin
        model_clear();
        bus.enable_writeback = 1'b0;
        bus.W_Control_in = 2'b00;
        bus.dr = '0; bus.aluout = '0; bus.pcout = '0; bus.memout = '0;
        bus.sr1 = '0; bus.sr2 = '0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        step("reset_state", 1'b0, 2'b00, 3'd0, 16'h0, 16'h0, 16'h0, 3'd3, 3'd5);
        step("alu_commit", 1'b1, 2'b00, 3'd3, 16'h8001, 16'h0, 16'h0, 3'd3, 3'd0);
        step("alu_visible", 1'b0, 2'b00, 3'd0, 16'hFFFF, 16'h0, 16'h0, 3'd3, 3'd3);
        step("mux_mem", 1'b1, 2'b01, 3'd5, 16'hFFFF, 16'h0, 16'h0000, 3'd5, 3'd6);
        step("mux_pc", 1'b1, 2'b10, 3'd6, 16'hFFFF, 16'h3005, 16'h1111, 3'd5, 3'd6);
        step("mux_after", 1'b0, 2'b00, 3'd0, 16'hFFFF, 16'h0, 16'h0, 3'd5, 3'd6);
        for (int i = 0; i < 5; i++)
            step("gate", 1'b0, 2'b00, 3'd2, 16'h1234, 16'h0, 16'h0, 3'd2, 3'd6);
        step("gate_x", 1'b0, 2'bxx, 3'd2, 16'h1234, 16'h4321, 16'h5555, 3'd2, 3'd3);
        step("illegal", 1'b1, 2'b11, 3'd1, 16'h7777, 16'h7777, 16'h7777, 3'd1, 3'd6);
        step("illegal_after", 1'b1, 2'b00, 3'd4, 16'h0042, 16'h0, 16'h0, 3'd1, 3'd4);
        step("err_sticky", 1'b0, 2'b00, 3'd0, 16'h0, 16'h0, 16'h0, 3'd4, 3'd1);
        step("b2b_first", 1'b1, 2'b00, 3'd7, 16'h0005, 16'h0, 16'h0, 3'd7, 3'd7);
        step("b2b_second", 1'b1, 2'b00, 3'd7, 16'hFFFE, 16'h0, 16'h0, 3'd7, 3'd7);
        step("b2b_result", 1'b0, 2'b00, 3'd0, 16'h0, 16'h0, 16'h0, 3'd7, 3'd7);
        rand_steps("rand", 300);
        reset = 1'b0;
        model_clear();
        for (int a = 0; a < 8; a += 2)
            step("in_reset", 1'b1, 2'b00, 3'(a), 16'h1357, 16'h0, 16'h0, 3'(a), 3'(a + 1));
        reset = 1'b1;
        rand_steps("rand_post", 100);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
